// File: rtl/range_sched_pkg.sv
// Shared types for the range-finder session scheduler.
package range_sched_pkg;

    localparam int NREQ_DEFAULT = 2;
    localparam int IDW          = $clog2(NREQ_DEFAULT);

    typedef enum logic [2:0] {
        IDLE,
        DUP,
        STREAM,
        DRAIN1,
        DRAIN2,
        FAULT
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters starting at ptr; one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; the parent owns the pointer register and decides when to advance.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic [$clog2(NREQ)-1:0] ptr_next
);
    localparam int IW = $clog2(NREQ);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
        ptr_next = ptr;
        if (advance && found) begin
            ptr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/range_session_sched.sv
// Shares one range-finder engine among NREQ sample streams, one whole session at a time.
// Latency: last beat in cycle L -> eng_finish at L+1, result at L+3 (single-beat session L+4).
// Backpressure: req_ready only for the granted requester; results are a pulse with no backpressure.
module range_session_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int LENW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        eng_data,
    output logic                    eng_go,
    output logic                    eng_finish,
    input  logic [WIDTH-1:0]        eng_range,
    input  logic                    eng_error,
    output logic                    res_valid,
    output logic [WIDTH-1:0]        res_range,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [LENW-1:0]         res_len,
    output logic                    res_err
);
    import range_sched_pkg::*;

    localparam int IW = $clog2(NREQ);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, ptr_nxt, lock_id, lock_id_nxt;
    logic [IW-1:0]    cur_id, gnt_idx, arb_ptr, id_nxt;
    logic [NREQ-1:0]  gnt;
    logic [LENW-1:0]  len, len_nxt, rlen_nxt;
    logic [WIDTH-1:0] sel_data, data_nxt, range_nxt;
    logic             sel_last, accept, adv;
    logic             go_nxt, fin_nxt, rv_nxt, err_nxt;

    assign adv = (state == IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .advance   (adv),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .ptr_next  (arb_ptr)
    );

    assign cur_id   = (state == IDLE) ? gnt_idx : lock_id;
    assign sel_data = req_data[int'(cur_id)*WIDTH +: WIDTH];
    assign sel_last = req_last[cur_id];
    assign accept   = |(req_valid & req_ready);

    // Ready is gated by reset so nothing is consumed while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n) begin
            case (state)
                IDLE:    req_ready = gnt;
                STREAM:  req_ready[lock_id] = 1'b1;
                default: req_ready = '0;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        lock_id_nxt = lock_id;
        len_nxt     = len;
        data_nxt    = eng_data;
        go_nxt      = 1'b0;
        fin_nxt     = 1'b0;
        rv_nxt      = 1'b0;
        range_nxt   = res_range;
        id_nxt      = res_id;
        rlen_nxt    = res_len;
        err_nxt     = res_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    data_nxt    = sel_data;
                    go_nxt      = 1'b1;
                    lock_id_nxt = gnt_idx;
                    ptr_nxt     = arb_ptr;
                    len_nxt     = LENW'(1);
                    state_nxt   = sel_last ? DUP : STREAM;
                end
            end
            // A lone beat is replayed as finish so the engine sees min == max.
            DUP: begin
                fin_nxt   = 1'b1;
                state_nxt = DRAIN1;
            end
            STREAM: begin
                if (accept) begin
                    data_nxt = sel_data;
                    len_nxt  = (&len) ? len : len + LENW'(1);
                    fin_nxt  = sel_last;
                    if (sel_last) begin
                        state_nxt = DRAIN1;
                    end
                end
            end
            DRAIN1: state_nxt = DRAIN2;
            DRAIN2: begin
                rv_nxt    = 1'b1;
                range_nxt = eng_range;
                id_nxt    = lock_id;
                rlen_nxt  = len;
                err_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
        // Engine error wins over any beat accepted in the same cycle; that beat is dropped.
        if (state != IDLE && state != FAULT && eng_error) begin
            state_nxt = FAULT;
            data_nxt  = eng_data;
            go_nxt    = 1'b0;
            fin_nxt   = 1'b0;
            rv_nxt    = 1'b1;
            range_nxt = '0;
            id_nxt    = lock_id;
            rlen_nxt  = len;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            lock_id    <= '0;
            len        <= '0;
            eng_data   <= '0;
            eng_go     <= 1'b0;
            eng_finish <= 1'b0;
            res_valid  <= 1'b0;
            res_range  <= '0;
            res_id     <= '0;
            res_len    <= '0;
            res_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            lock_id    <= lock_id_nxt;
            len        <= len_nxt;
            eng_data   <= data_nxt;
            eng_go     <= go_nxt;
            eng_finish <= fin_nxt;
            res_valid  <= rv_nxt;
            res_range  <= range_nxt;
            res_id     <= id_nxt;
            res_len    <= rlen_nxt;
            res_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_range_session_sched.sv
// Randomized scoreboard bench for range_session_sched with a behavioural range-finder engine as load.
module tb_range_session_sched;
    localparam int WIDTH   = 8;
    localparam int NREQ    = 2;
    localparam int LENW    = 8;
    localparam int IW      = $clog2(NREQ);
    localparam int LEN_MAX = (1 << LENW) - 1;

    typedef struct { logic [WIDTH-1:0] d; bit last; int gap; } beat_t;
    typedef struct { int id; int rng; int len; bit err; int cyc; } res_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_last, req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]      eng_data, eng_range;
    logic                  eng_go, eng_finish, eng_error;
    logic                  res_valid, res_err;
    logic [WIDTH-1:0]      res_range;
    logic [IW-1:0]         res_id;
    logic [LENW-1:0]       res_len;
    logic                  force_err;

    always #5 clk = ~clk;

    range_session_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LENW(LENW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .eng_data(eng_data), .eng_go(eng_go),
        .eng_finish(eng_finish), .eng_range(eng_range), .eng_error(eng_error),
        .res_valid(res_valid), .res_range(res_range), .res_id(res_id),
        .res_len(res_len), .res_err(res_err)
    );

    // Range-finder engine: go loads min/max, every busy cycle folds in data, finish publishes max-min.
    logic [WIDTH-1:0] e_min, e_max;
    logic             e_busy;
    assign eng_error = force_err;

    function automatic logic [WIDTH-1:0] umin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction
    function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            e_min <= '0; e_max <= '0; e_busy <= 1'b0; eng_range <= '0;
        end else if (eng_go) begin
            e_min <= eng_data; e_max <= eng_data; e_busy <= 1'b1;
        end else if (e_busy) begin
            e_min <= umin(e_min, eng_data);
            e_max <= umax(e_max, eng_data);
            if (eng_finish) begin
                e_busy    <= 1'b0;
                eng_range <= umax(e_max, eng_data) - umin(e_min, eng_data);
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model state: session ownership, blackout after a session, pointer, engine expectations.
    beat_t            bq [NREQ][$];
    res_t             expq [$];
    int               m_ptr, m_id, m_cnt, m_block;
    bit               m_active, m_fault, m_dupfin, m_go, m_fin;
    logic [WIDTH-1:0] m_dat, m_min, m_max;

    task automatic model_reset();
        m_ptr = 0; m_id = 0; m_cnt = 0; m_block = 0;
        m_active = 0; m_fault = 0; m_dupfin = 0; m_go = 0; m_fin = 0;
        m_dat = '0; m_min = '0; m_max = '0;
        expq.delete();
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit busy();
        bit any = 0;
        for (int i = 0; i < NREQ; i++) if (bq[i].size() > 0) any = 1;
        return any || expq.size() > 0 || m_active || m_block > 0;
    endfunction

    task automatic add_beat(input int r, input int d, input bit last, input int gap);
        beat_t b;
        b.d = WIDTH'(d); b.last = last; b.gap = gap;
        bq[r].push_back(b);
    endtask

    task automatic add_sess(input int r, input int n, input int maxgap);
        for (int k = 0; k < n; k++)
            add_beat(r, int'($urandom_range(255, 0)), k == n - 1, int'($urandom_range(maxgap, 0)));
    endtask

    task automatic step(input bit err = 1'b0);
        logic [NREQ-1:0]  exp_rdy, hs;
        bit               n_go, n_fin;
        logic [WIDTH-1:0] n_dat;
        beat_t            b;
        int               w;
        @(negedge clk);
        chk("eng_go", eng_go, m_go);
        chk("eng_finish", eng_finish, m_fin);
        chk("eng_data", eng_data, m_dat);
        force_err = err;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            if (bq[i].size() > 0) begin
                b = bq[i][0];
                if (b.gap > 0) begin
                    b.gap--;
                    bq[i][0] = b;
                end else begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = b.last;
                    req_data[i*WIDTH +: WIDTH] = b.d;
                end
            end
        end
        #1;
        exp_rdy = '0;
        if (!m_fault && m_block == 0) begin
            if (m_active) exp_rdy[m_id] = 1'b1;
            else begin
                w = rr_pick(req_valid);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
        end
        chk("req_ready", req_ready, exp_rdy);
        hs    = req_valid & req_ready;
        n_go  = 0;
        n_fin = 0;
        n_dat = m_dat;
        if (err && !m_fault && (m_active || m_block > 0)) begin
            m_fault = 1; m_active = 0; m_block = 0; m_dupfin = 0;
            expq.push_back('{id: m_id, rng: 0, len: 0, err: 1'b1, cyc: cyc + 1});
        end else if (m_block > 0) begin
            n_fin = m_dupfin;
            m_dupfin = 0;
            m_block--;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && bq[i].size() > 0) begin
                b = bq[i].pop_front();
                if (!m_fault) begin
                    n_dat = b.d;
                    if (!m_active) begin
                        n_go = 1; m_id = i; m_ptr = (i + 1) % NREQ; m_cnt = 1;
                        m_min = b.d; m_max = b.d;
                        if (b.last) begin
                            m_block = 3; m_dupfin = 1;
                            expq.push_back('{id: i, rng: 0, len: 1, err: 1'b0, cyc: cyc + 4});
                        end else m_active = 1;
                    end else begin
                        m_cnt++;
                        if (b.d < m_min) m_min = b.d;
                        if (b.d > m_max) m_max = b.d;
                        if (b.last) begin
                            n_fin = 1; m_active = 0; m_block = 2;
                            expq.push_back('{id: i, rng: int'(m_max - m_min),
                                             len: (m_cnt > LEN_MAX) ? LEN_MAX : m_cnt,
                                             err: 1'b0, cyc: cyc + 3});
                        end
                    end
                end
            end
        end
        m_go = n_go; m_fin = n_fin; m_dat = n_dat;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (busy() && n < budget) begin step(); n++; end
        if (busy()) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: sessions still pending after %0d cycles, required none", budget);
        end
        repeat (2) step();
    endtask

    task automatic wait_stream(input int beats, input int budget);
        int n = 0;
        while (!(m_active && m_cnt >= beats) && n < budget) begin step(); n++; end
        if (!(m_active && m_cnt >= beats)) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_timeout: session not streaming after %0d cycles", budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_eng_go"}, eng_go, 0);
        chk({tag, "_eng_finish"}, eng_finish, 0);
        chk({tag, "_eng_data"}, eng_data, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_range"}, res_range, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_res_len"}, res_len, 0);
        chk({tag, "_res_err"}, res_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        force_err = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) bq[i].delete();
        model_reset();
        @(negedge clk);
        #1;
        check_all_zero("reset");
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic monitor();
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL res_unexpected: got result range %0d id %0d len %0d err %0d at cycle %0d, required none",
                             res_range, res_id, res_len, res_err, cyc);
                end else begin
                    r = expq.pop_front();
                    chk("res_cycle", cyc, r.cyc);
                    chk("res_err", res_err, r.err);
                    chk("res_range", res_range, r.rng);
                    chk("res_id", res_id, r.id);
                    if (!r.err) chk("res_len", res_len, r.len);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        force_err = 1'b0;
        req_valid = '1;
        req_last = '0;
        req_data = '1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("init");
        req_valid = '0;
        rst_n = 1'b1;
        fork monitor(); join_none

        // Three-beat session from requester 0, then a lone beat from requester 1.
        add_beat(0, 10, 0, 0); add_beat(0, 40, 0, 0); add_beat(0, 25, 1, 0);
        run_idle(50);
        add_beat(1, 77, 1, 0);
        run_idle(50);

        // Both requesters always valid with two-beat sessions: grants must alternate.
        for (int s = 0; s < 4; s++) begin
            add_sess(0, 2, 0);
            add_sess(1, 2, 0);
        end
        run_idle(200);

        // Stall mid-session: engine data must hold 50 while the requester idles.
        add_beat(0, 50, 0, 0); add_beat(0, 20, 0, 3); add_beat(0, 90, 1, 0);
        run_idle(50);

        // Beat counter saturates.
        add_sess(1, 260, 0);
        run_idle(400);

        // Randomized contention.
        for (int s = 0; s < 40; s++)
            add_sess(int'($urandom_range(NREQ - 1, 0)), int'($urandom_range(6, 1)), int'($urandom_range(3, 0)));
        run_idle(5000);

        // Engine error during streaming: one error result, then everything blocked until reset.
        add_sess(0, 10, 0);
        add_sess(1, 3, 0);
        wait_stream(3, 50);
        step(1'b1);
        repeat (20) step();
        chk("fault_result_count", expq.size(), 0);
        do_reset();
        add_beat(1, 5, 0, 0); add_beat(1, 9, 1, 0);
        run_idle(50);

        // Reset mid-stream with pointer at 1: session discarded and requester 0 wins the next tie.
        add_beat(0, 1, 0, 0); add_beat(0, 2, 0, 0); add_beat(0, 3, 0, 2); add_beat(0, 4, 1, 0);
        wait_stream(2, 50);
        do_reset();
        add_beat(0, 11, 1, 0);
        add_beat(1, 22, 1, 0);
        run_idle(50);

        chk("leftover_results", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
